// File: rtl/pwm_multichannel.sv
// Multichannel PWM generator with prescaled tick, edge/center-aligned counting
// and shadow duty registers that load into the active set only at period boundaries.
module pwm_multichannel #(
  parameter int CHANNELS   = 16,
  parameter int RES        = 8,
  parameter int PRESCALE_W = 8,
  parameter int CH_W       = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  center,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [CHANNELS-1:0]   en_out,
  input  logic [CHANNELS-1:0]   en_pwm,
  input  logic                  duty_wr,
  input  logic [CH_W-1:0]       duty_ch,
  input  logic [RES-1:0]        duty_val,
  output logic [CHANNELS-1:0]   out,
  output logic                  period_start
);

  localparam logic [RES-1:0] CNT_MAX    = {{(RES-1){1'b1}}, 1'b0};
  localparam logic [RES-1:0] CNT_MAX_M1 = CNT_MAX - RES'(1);
  localparam logic [RES-1:0] CNT_ONE    = RES'(1);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
  typedef enum logic {MODE_EDGE, MODE_CENTER} mode_e;

  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [RES-1:0]        cnt_q, cnt_d;
  dir_e                  dir_q, dir_d;
  mode_e                 mode_q, mode_d;
  logic [RES-1:0]        shadow_q [CHANNELS];
  logic [RES-1:0]        shadow_d [CHANNELS];
  logic [RES-1:0]        active_q [CHANNELS];
  logic [RES-1:0]        active_d [CHANNELS];
  logic [CHANNELS-1:0]   out_q, out_d;
  logic                  period_start_q, period_start_d;

  logic tick;
  logic boundary;
  logic load;

  // The >= compare lets a freshly lowered prescale fire at once instead of wrapping.
  always_comb begin
    tick     = run && (pre_cnt_q >= prescale);
    boundary = 1'b0;
    if (tick) begin
      if (mode_q == MODE_EDGE) begin
        boundary = (cnt_q == CNT_MAX);
      end else begin
        boundary = (dir_q == DIR_DOWN) && (cnt_q == CNT_ONE);
      end
    end
    load = !run || boundary;
  end

  always_comb begin
    pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
    if (!run || tick) begin
      pre_cnt_d = '0;
    end
  end

  // Both boundary kinds (and any mode change) restart the period from cnt=0 counting up.
  always_comb begin
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    if (load) begin
      cnt_d  = '0;
      dir_d  = DIR_UP;
      mode_d = center ? MODE_CENTER : MODE_EDGE;
    end else if (tick) begin
      if (mode_q == MODE_EDGE) begin
        cnt_d = cnt_q + RES'(1);
      end else if (dir_q == DIR_UP) begin
        cnt_d = cnt_q + RES'(1);
        if (cnt_q == CNT_MAX_M1) begin
          dir_d = DIR_DOWN;
        end
      end else begin
        cnt_d = cnt_q - RES'(1);
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      shadow_d[c] = shadow_q[c];
      if (duty_wr && (duty_ch == CH_W'(c))) begin
        shadow_d[c] = duty_val;
      end
      active_d[c] = load ? shadow_q[c] : active_q[c];
    end
  end

  always_comb begin
    out_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (!en_out[c]) begin
        out_d[c] = 1'b0;
      end else if (!en_pwm[c]) begin
        out_d[c] = 1'b1;
      end else if (!run) begin
        out_d[c] = 1'b0;
      end else begin
        out_d[c] = (cnt_q < active_q[c]);
      end
    end
    period_start_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q      <= '0;
      cnt_q          <= '0;
      dir_q          <= DIR_UP;
      mode_q         <= MODE_EDGE;
      out_q          <= '0;
      period_start_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        shadow_q[c] <= '0;
        active_q[c] <= '0;
      end
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      mode_q         <= mode_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
      for (int c = 0; c < CHANNELS; c++) begin
        shadow_q[c] <= shadow_d[c];
        active_q[c] <= active_d[c];
      end
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Self-checking bench for pwm_multichannel: a period-phase model checked every cycle,
// plus per-period high-time measurements against hand-computed values.
module tb_pwm_multichannel;

  localparam int CH  = 16;
  localparam int RES = 8;
  localparam int PW  = 8;
  localparam int CW  = 6;
  localparam int M   = 254;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          center = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic [CH-1:0] en_out = '0;
  logic [CH-1:0] en_pwm = '0;
  logic          duty_wr = 1'b0;
  logic [CW-1:0] duty_ch = '0;
  logic [RES-1:0] duty_val = '0;
  logic [CH-1:0] out;
  logic          period_start;

  pwm_multichannel #(
    .CHANNELS(CH), .RES(RES), .PRESCALE_W(PW), .CH_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .center(center), .prescale(prescale),
    .en_out(en_out), .en_pwm(en_pwm), .duty_wr(duty_wr), .duty_ch(duty_ch),
    .duty_val(duty_val), .out(out), .period_start(period_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position within the period as a phase; cnt derived from it arithmetically.
  int            m_pre = 0;
  int            m_phase = 0;
  bit            m_mode = 1'b0;
  int            m_shadow [CH];
  int            m_active [CH];
  logic [CH-1:0] exp_out = '0;
  logic          exp_ps = 1'b0;

  initial begin
    for (int c = 0; c < CH; c++) begin
      m_shadow[c] = 0;
      m_active[c] = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pre = 0; m_phase = 0; m_mode = 1'b0; exp_out = '0; exp_ps = 1'b0;
        for (int c = 0; c < CH; c++) begin
          m_shadow[c] = 0;
          m_active[c] = 0;
        end
      end else begin
        int cur;
        int period;
        bit tk;
        logic [CH-1:0] nxt;
        cur = (!m_mode || m_phase <= M) ? m_phase : 2 * M - m_phase;
        for (int c = 0; c < CH; c++) begin
          if (!en_out[c]) nxt[c] = 1'b0;
          else if (!en_pwm[c]) nxt[c] = 1'b1;
          else if (!run) nxt[c] = 1'b0;
          else nxt[c] = (cur < m_active[c]);
        end
        exp_ps = 1'b0;
        if (!run) begin
          m_pre = 0; m_phase = 0; m_mode = center;
          for (int c = 0; c < CH; c++) m_active[c] = m_shadow[c];
        end else begin
          tk = (m_pre >= int'(prescale));
          m_pre = tk ? 0 : m_pre + 1;
          if (tk) begin
            period = m_mode ? 2 * M : M + 1;
            if (m_phase == period - 1) begin
              m_phase = 0;
              m_mode = center;
              exp_ps = 1'b1;
              for (int c = 0; c < CH; c++) m_active[c] = m_shadow[c];
            end else begin
              m_phase = m_phase + 1;
            end
          end
        end
        if (duty_wr && int'(duty_ch) < CH) m_shadow[int'(duty_ch)] = int'(duty_val);
        exp_out = nxt;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check_output("cycle_out", out, exp_out);
        check_output("cycle_period_start", period_start, exp_ps);
      end
    end
  end

  int m_hi [CH];
  int m_len;
  int m_lead;

  task automatic wait_ps();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      if (period_start) found = 1'b1;
    end
    if (!found) check_output("wait_period_start_timeout", 0, 1);
  endtask

  // Starts on a period_start sample and ends on the next one; optional write / prescale change.
  task automatic apply_stimulus(input int wr_at, input int wr_ch, input int wr_val,
                                input int pre_at, input int pre_val);
    bit found;
    bit lead_open;
    found = 1'b0;
    lead_open = 1'b1;
    m_len = 0;
    m_lead = 0;
    for (int c = 0; c < CH; c++) m_hi[c] = 0;
    for (int i = 1; i <= 3000 && !found; i++) begin
      duty_wr = 1'b0;
      if (i == wr_at) begin
        duty_wr  = 1'b1;
        duty_ch  = CW'(wr_ch);
        duty_val = RES'(wr_val);
      end
      if (i == pre_at) prescale = PW'(pre_val);
      @(negedge clk);
      m_len = i;
      for (int c = 0; c < CH; c++) m_hi[c] += int'(out[c]);
      if (lead_open && out[0]) m_lead++;
      else lead_open = 1'b0;
      if (period_start) found = 1'b1;
    end
    duty_wr = 1'b0;
    if (!found) check_output("measure_timeout", 0, 1);
  endtask

  task automatic write_duty(input int ch, input int val);
    duty_wr  = 1'b1;
    duty_ch  = CW'(ch);
    duty_val = RES'(val);
    @(negedge clk);
    duty_wr  = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_output("reset_out", out, 0);
    check_output("reset_period_start", period_start, 0);
    rst_n = 1'b1;

    en_out = 16'hFFFF; en_pwm = 16'hFFFF; prescale = 0; center = 1'b0;
    write_duty(0, 0); write_duty(1, 1); write_duty(2, 128); write_duty(3, 255);
    run = 1'b1;
    wait_ps();
    apply_stimulus(-1, 0, 0, -1, 0);
    check_output("edge_len", m_len, 255);
    check_output("edge_hi_ch0", m_hi[0], 0);
    check_output("edge_hi_ch1", m_hi[1], 1);
    check_output("edge_hi_ch2", m_hi[2], 128);
    check_output("edge_hi_ch3", m_hi[3], 255);

    apply_stimulus(100, 2, 64, -1, 0);
    check_output("shadow_mid_cur", m_hi[2], 128);
    apply_stimulus(-1, 0, 0, -1, 0);
    check_output("shadow_mid_next", m_hi[2], 64);
    apply_stimulus(100, 2, 128, -1, 0);
    check_output("shadow_restore_cur", m_hi[2], 64);
    apply_stimulus(255, 2, 64, -1, 0);
    check_output("shadow_bnd_cur", m_hi[2], 128);
    apply_stimulus(-1, 0, 0, -1, 0);
    check_output("shadow_bnd_next", m_hi[2], 128);
    apply_stimulus(-1, 0, 0, -1, 0);
    check_output("shadow_bnd_later", m_hi[2], 64);

    center = 1'b1;
    apply_stimulus(5, 0, 10, -1, 0);
    check_output("mode_switch_len", m_len, 255);
    check_output("mode_switch_hi_ch0", m_hi[0], 0);
    apply_stimulus(-1, 0, 0, -1, 0);
    check_output("center_len", m_len, 508);
    check_output("center_hi_ch0", m_hi[0], 19);
    check_output("center_lead_ch0", m_lead, 10);
    check_output("center_hi_ch1", m_hi[1], 1);
    check_output("center_hi_ch2", m_hi[2], 127);
    check_output("center_hi_ch3", m_hi[3], 508);

    center = 1'b0;
    prescale = 3;
    apply_stimulus(5, 0, 128, -1, 0);
    apply_stimulus(-1, 0, 0, -1, 0);
    check_output("pre3_len", m_len, 1020);
    check_output("pre3_hi_ch0", m_hi[0], 512);
    apply_stimulus(-1, 0, 0, 4, 1);
    check_output("pre_drop_len", m_len, 512);
    apply_stimulus(-1, 0, 0, -1, 0);
    check_output("pre1_len", m_len, 510);
    check_output("pre1_hi_ch0", m_hi[0], 256);

    prescale = 0;
    en_out[6] = 1'b0;
    en_pwm[5] = 1'b0;
    apply_stimulus(5, 5, 100, -1, 0);
    apply_stimulus(5, 6, 100, -1, 0);
    check_output("static_hi_ch5", m_hi[5], 255);
    check_output("disabled_hi_ch6", m_hi[6], 0);
    apply_stimulus(5, 20, 200, -1, 0);
    apply_stimulus(-1, 0, 0, -1, 0);
    check_output("range_hi_ch4", m_hi[4], 0);
    check_output("range_hi_ch2", m_hi[2], 64);
    check_output("range_hi_ch0", m_hi[0], 128);

    run = 1'b0;
    repeat (3) @(negedge clk);
    check_output("run0_out", out, 16'h0020);
    run = 1'b1;
    wait_ps();
    apply_stimulus(-1, 0, 0, -1, 0);
    check_output("rerun_len", m_len, 255);

    repeat (20) @(negedge clk);
    check_output("pre_reset_ch3_high", out[3], 1);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_reset_out", out, 0);
    check_output("async_reset_ps", period_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ps();
    apply_stimulus(-1, 0, 0, -1, 0);
    check_output("post_reset_len", m_len, 255);
    check_output("post_reset_hi_ch3", m_hi[3], 0);
    check_output("post_reset_hi_ch2", m_hi[2], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
